// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch front end.
// Holds the opcode field layout and the JMPR encoding used by the optional predecoder.
package fetch_pkg;

   // Opcode field width, taken from the top of the instruction word
   localparam int OPC_W = 4;

   // JMPR: PC-relative jump, 6-bit signed immediate in instr[5:0]
   localparam logic [OPC_W-1:0] OPC_JMPR = 4'hE;

   // Width of the JMPR immediate field
   localparam int JIMM_W = 6;

   // All-zero word presented to decode when no real instruction is available
   localparam int NOP_INSTR = 0;

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational JMPR detection and jump-target computation.
// Target = fetch PC + sign-extended 6-bit immediate, modulo 2^PC_W.
module fetch_predecode
   import fetch_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic [OPC_W-1:0]  opc_i,
   input  logic [JIMM_W-1:0] imm_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              is_jmpr_o,
   output logic [PC_W-1:0]   target_o
);

   logic [PC_W-1:0] imm_ext;

   assign imm_ext   = {{(PC_W-JIMM_W){imm_i[JIMM_W-1]}}, imm_i};
   assign is_jmpr_o = (opc_i == OPC_JMPR);
   assign target_o  = pc_i + imm_ext;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end feeding the IF/ID register.
// Drives a 1-cycle-latency ROM, tracks the in-flight fetch, honours stall and
// execute redirects (redirect wins over stall, reset wins over both).
// Build macro FETCH_JMPR_PREDICT_EN: predecode JMPR words and redirect fetch early.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 10,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rstn,
   output logic [PC_W-1:0]    rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [INSTR_W-1:0] instr_id,
   output logic [PC_W-1:0]    pc_id,
   output logic               valid_id,
   output logic               pred_taken_id
);

   logic [PC_W-1:0]    pc_f_q, pc_f_d;
   logic [PC_W-1:0]    f_pc_q, f_pc_d;
   logic               f_valid_q, f_valid_d;
   logic [INSTR_W-1:0] instr_id_q, instr_id_d;
   logic [PC_W-1:0]    pc_id_q, pc_id_d;
   logic               valid_id_q, valid_id_d;
   logic               pred_taken_q, pred_taken_d;

   logic               jmpr_hit;
   logic [PC_W-1:0]    jmpr_target;

`ifdef FETCH_JMPR_PREDICT_EN
   logic jmpr_opc_match;

   fetch_predecode #(
      .PC_W (PC_W)
   ) u_predecode (
      .opc_i     (rom_data[INSTR_W-1 -: OPC_W]),
      .imm_i     (rom_data[JIMM_W-1:0]),
      .pc_i      (f_pc_q),
      .is_jmpr_o (jmpr_opc_match),
      .target_o  (jmpr_target)
   );

   // Only a real, advancing fetch may steer the PC
   assign jmpr_hit = jmpr_opc_match & f_valid_q & ~stall & ~redirect_valid;
`else
   assign jmpr_hit    = 1'b0;
   assign jmpr_target = pc_f_q;
`endif

   // During stall the in-flight address is re-read so rom_data stays paired with f_pc
   assign rom_addr = !rstn          ? RESET_PC    :
                     redirect_valid ? redirect_pc :
                     stall          ? f_pc_q      : pc_f_q;

   assign instr_id      = instr_id_q;
   assign pc_id         = pc_id_q;
   assign valid_id      = valid_id_q;
   assign pred_taken_id = pred_taken_q;

   // Next-state: redirect flushes, stall holds, otherwise advance one word
   always_comb begin
      pc_f_d       = pc_f_q;
      f_pc_d       = f_pc_q;
      f_valid_d    = f_valid_q;
      instr_id_d   = instr_id_q;
      pc_id_d      = pc_id_q;
      valid_id_d   = valid_id_q;
      pred_taken_d = pred_taken_q;
      if (redirect_valid) begin
         instr_id_d   = INSTR_W'(NOP_INSTR);
         valid_id_d   = 1'b0;
         pred_taken_d = 1'b0;
         f_pc_d       = redirect_pc;
         f_valid_d    = 1'b1;
         pc_f_d       = redirect_pc + PC_W'(1);
      end else if (!stall) begin
         instr_id_d   = f_valid_q ? rom_data : INSTR_W'(NOP_INSTR);
         pc_id_d      = f_pc_q;
         valid_id_d   = f_valid_q;
         pred_taken_d = jmpr_hit;
         f_pc_d       = pc_f_q;
         if (jmpr_hit) begin
            // Sequential word issued this cycle is killed: one bubble
            pc_f_d    = jmpr_target;
            f_valid_d = 1'b0;
         end else begin
            pc_f_d    = pc_f_q + PC_W'(1);
            f_valid_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_f_q       <= RESET_PC;
         f_pc_q       <= '0;
         f_valid_q    <= 1'b0;
         instr_id_q   <= INSTR_W'(NOP_INSTR);
         pc_id_q      <= '0;
         valid_id_q   <= 1'b0;
         pred_taken_q <= 1'b0;
      end else begin
         pc_f_q       <= pc_f_d;
         f_pc_q       <= f_pc_d;
         f_valid_q    <= f_valid_d;
         instr_id_q   <= instr_id_d;
         pc_id_q      <= pc_id_d;
         valid_id_q   <= valid_id_d;
         pred_taken_q <= pred_taken_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// Reference model: a stream of expected ID entries built from PC sequencing rules.
// Honours FETCH_JMPR_PREDICT_EN the same way the design does.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int PW = 10;
   localparam int IW = 16;
   localparam logic [PW-1:0] RST_PC   = 10'd0;
   localparam logic [PW-1:0] RST_PC_W = 10'd1022;
   localparam logic [IW-1:0] ADD_W    = 16'h1012;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic [PW-1:0] rom_addr, pc_id;
   logic [IW-1:0] rom_data, instr_id;
   logic          valid_id, pred_taken_id;

   logic          stall_w = 1'b0, redir_w = 1'b0;
   logic [PW-1:0] rpc_w = '0;
   logic [PW-1:0] rom_addr_w, pc_id_w;
   logic [IW-1:0] rom_data_w, instr_id_w;
   logic          valid_id_w, pred_w;

   logic [IW-1:0] rom [1024];

   always @(posedge clk) rom_data   <= rom[rom_addr];
   always @(posedge clk) rom_data_w <= rom[rom_addr_w];

   fetch_stage #(.PC_W(PW), .INSTR_W(IW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(rom_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id), .pred_taken_id(pred_taken_id)
   );

   fetch_stage #(.PC_W(PW), .INSTR_W(IW), .RESET_PC(RST_PC_W)) dut_w (
      .clk(clk), .rstn(rstn), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
      .stall(stall_w), .redirect_valid(redir_w), .redirect_pc(rpc_w),
      .instr_id(instr_id_w), .pc_id(pc_id_w), .valid_id(valid_id_w), .pred_taken_id(pred_w)
   );

   typedef struct packed {
      logic [PW-1:0] pc;
      logic          v;
   } fetch_t;

   fetch_t        q[$];
   logic [PW-1:0] m_next = RST_PC, m_pc = '0;
   logic [IW-1:0] m_instr = '0;
   logic          m_valid = 1'b0, m_pred = 1'b0;
   int            total = 0, bad = 0;

   // Expected ID contents after one clock edge with the given inputs
   task automatic model_edge(input logic s, input logic r, input logic [PW-1:0] rp, input logic rn);
      fetch_t e;
      logic   hit;
      if (!rn) begin
         q.delete();
         m_next = RST_PC; m_instr = '0; m_pc = '0; m_valid = 1'b0; m_pred = 1'b0;
      end else if (r) begin
         m_valid = 1'b0; m_instr = '0; m_pred = 1'b0;
         q.delete();
         e.pc = rp; e.v = 1'b1;
         q.push_back(e);
         m_next = rp + 10'd1;
      end else if (!s) begin
         if (q.size() > 0) e = q.pop_front();
         else begin e.pc = '0; e.v = 1'b0; end
         m_valid = e.v;
         m_pc    = e.pc;
         m_instr = e.v ? rom[e.pc] : '0;
         hit     = 1'b0;
`ifdef FETCH_JMPR_PREDICT_EN
         begin
            logic [IW-1:0] w;
            int            off;
            w = rom[e.pc];
            if (e.v && w[IW-1 -: OPC_W] == OPC_JMPR) begin
               hit = 1'b1;
               off = int'(w[5:0]);
               if (off >= 32) off = off - 64;
               m_next = PW'((int'(e.pc) + off + 1024) % 1024);
            end
         end
`endif
         m_pred = hit;
         if (hit) begin
            e.pc = '0; e.v = 1'b0;
            q.push_back(e);
         end else begin
            e.pc = m_next; e.v = 1'b1;
            q.push_back(e);
            m_next = m_next + 10'd1;
         end
      end
   endtask

   task automatic advance(input logic s, input logic r, input logic [PW-1:0] rp, input logic rn);
      stall = s; redirect_valid = r; redirect_pc = rp; rstn = rn;
      @(posedge clk);
      model_edge(s, r, rp, rn);
      #1;
      $display("t=%0t rstn=%0b stall=%0b redir=%0b->%0d | id v=%0b pc=%0d instr=%h pred=%0b",
               $time, rn, s, r, rp, valid_id, pc_id, instr_id, pred_taken_id);
   endtask

   task automatic test_reset();
      advance(1'b1, 1'b1, 10'd77, 1'b0);
      total++;
      if (rom_addr !== RST_PC) begin
         bad++; $display("FAIL reset_rom_addr: got %0d expected %0d", rom_addr, RST_PC);
      end
      advance(1'b0, 1'b0, '0, 1'b0);
      total++;
      if (valid_id !== 1'b0 || instr_id !== '0 || pc_id !== '0 || pred_taken_id !== 1'b0) begin
         bad++; $display("FAIL reset_regs: got v=%0b pc=%0d instr=%h pred=%0b expected all zero",
                         valid_id, pc_id, instr_id, pred_taken_id);
      end
      for (int k = 1; k <= 6; k++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (instr_id !== m_instr || valid_id !== m_valid || pred_taken_id !== m_pred || (m_valid && pc_id !== m_pc)) begin
            bad++; $display("FAIL reset_seq: got v=%0b pc=%0d instr=%h pred=%0b expected v=%0b pc=%0d instr=%h pred=%0b",
                            valid_id, pc_id, instr_id, pred_taken_id, m_valid, m_pc, m_instr, m_pred);
         end
         if (k == 1) begin
            total++;
            if (valid_id !== 1'b0) begin
               bad++; $display("FAIL first_edge_valid: got %0b expected 0", valid_id);
            end
         end
         if (k == 6) begin
            total++;
            if (valid_id !== 1'b1 || pc_id !== 10'd4 || instr_id !== ADD_W) begin
               bad++; $display("FAIL add_at_6: got v=%0b pc=%0d instr=%h expected v=1 pc=4 instr=%h",
                               valid_id, pc_id, instr_id, ADD_W);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         if (valid_id === 1'b1 && pc_id === 10'd8) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL stall_wait: pc_id=8 never reached, last pc=%0d", pc_id);
      end
      for (int k = 0; k < 3; k++) begin
         advance(1'b1, 1'b0, '0, 1'b1);
         total++;
         if (valid_id !== 1'b1 || pc_id !== 10'd8 || instr_id !== rom[8]) begin
            bad++; $display("FAIL stall_hold: got v=%0b pc=%0d instr=%h expected v=1 pc=8 instr=%h",
                            valid_id, pc_id, instr_id, rom[8]);
         end
      end
      for (int k = 9; k <= 10; k++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (valid_id !== 1'b1 || pc_id !== PW'(k) || instr_id !== rom[k]) begin
            bad++; $display("FAIL stall_release: got v=%0b pc=%0d instr=%h expected v=1 pc=%0d instr=%h",
                            valid_id, pc_id, instr_id, k, rom[k]);
         end
      end
   endtask

   task automatic test_redirect(input logic with_stall, input logic [PW-1:0] at_pc);
      logic found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         if (valid_id === 1'b1 && pc_id === at_pc) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL redirect_wait: pc_id=%0d never reached, last pc=%0d", at_pc, pc_id);
      end
      advance(with_stall, 1'b1, 10'd100, 1'b1);
      total++;
      if (valid_id !== 1'b0 || instr_id !== '0 || pred_taken_id !== 1'b0) begin
         bad++; $display("FAIL redirect_bubble(stall=%0b): got v=%0b instr=%h expected v=0 instr=0",
                         with_stall, valid_id, instr_id);
      end
      for (int k = 100; k <= 102; k++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (instr_id !== m_instr || valid_id !== m_valid || pred_taken_id !== m_pred || (m_valid && pc_id !== m_pc)) begin
            bad++; $display("FAIL redirect_model(stall=%0b): got v=%0b pc=%0d instr=%h expected v=%0b pc=%0d instr=%h",
                            with_stall, valid_id, pc_id, instr_id, m_valid, m_pc, m_instr);
         end
         total++;
         if (valid_id !== 1'b1 || pc_id !== PW'(k)) begin
            bad++; $display("FAIL redirect_target(stall=%0b): got v=%0b pc=%0d expected v=1 pc=%0d",
                            with_stall, valid_id, pc_id, k);
         end
      end
   endtask

   task automatic test_jmpr();
      logic found = 1'b0;
      advance(1'b0, 1'b1, 10'd37, 1'b1);
      for (int i = 0; i < 10 && !found; i++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         if (valid_id === 1'b1 && pc_id === 10'd40) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL jmpr_wait: pc_id=40 never reached, last pc=%0d", pc_id);
      end
`ifdef FETCH_JMPR_PREDICT_EN
      total++;
      if (pred_taken_id !== 1'b1) begin
         bad++; $display("FAIL jmpr_pred: got pred=%0b expected 1", pred_taken_id);
      end
      advance(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (valid_id !== 1'b0) begin
         bad++; $display("FAIL jmpr_bubble: got v=%0b expected 0", valid_id);
      end
      advance(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (valid_id !== 1'b1 || pc_id !== 10'd20 || pred_taken_id !== 1'b0) begin
         bad++; $display("FAIL jmpr_target: got v=%0b pc=%0d pred=%0b expected v=1 pc=20 pred=0",
                         valid_id, pc_id, pred_taken_id);
      end
`else
      total++;
      if (pred_taken_id !== 1'b0) begin
         bad++; $display("FAIL jmpr_nopred: got pred=%0b expected 0", pred_taken_id);
      end
      advance(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (valid_id !== 1'b1 || pc_id !== 10'd41 || pred_taken_id !== 1'b0) begin
         bad++; $display("FAIL jmpr_seq: got v=%0b pc=%0d pred=%0b expected v=1 pc=41 pred=0",
                         valid_id, pc_id, pred_taken_id);
      end
`endif
   endtask

   task automatic test_random();
      logic          s, r, rn;
      logic [PW-1:0] rp;
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 99) < 25);
         r  = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 2))
            0:       rp = PW'($urandom_range(590, 710));
            1:       rp = PW'($urandom_range(1015, 1023));
            default: rp = PW'($urandom);
         endcase
         advance(s, r, rp, rn);
         total++;
         if (instr_id !== m_instr || valid_id !== m_valid || pred_taken_id !== m_pred || (m_valid && pc_id !== m_pc)) begin
            bad++; $display("FAIL random: got v=%0b pc=%0d instr=%h pred=%0b expected v=%0b pc=%0d instr=%h pred=%0b",
                            valid_id, pc_id, instr_id, pred_taken_id, m_valid, m_pc, m_instr, m_pred);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_pc;
      advance(1'b0, 1'b0, '0, 1'b0);
      advance(1'b0, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         advance(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (k == 1) begin
            if (valid_id_w !== 1'b0) begin
               bad++; $display("FAIL wrap_first: got v=%0b expected 0", valid_id_w);
            end
         end else begin
            exp_pc = (1022 + k - 2) % 1024;
            if (valid_id_w !== 1'b1 || pc_id_w !== PW'(exp_pc) || instr_id_w !== rom[exp_pc]) begin
               bad++; $display("FAIL wrap_seq: got v=%0b pc=%0d instr=%h expected v=1 pc=%0d instr=%h",
                               valid_id_w, pc_id_w, instr_id_w, exp_pc, rom[exp_pc]);
            end
         end
      end
   endtask

   initial begin
      logic [IW-1:0] w;
      for (int i = 0; i < 1024; i++) begin
         w = IW'($urandom);
         if (w[IW-1 -: OPC_W] == OPC_JMPR) w[IW-1] = ~w[IW-1];
         rom[i] = w;
      end
      for (int i = 600; i <= 700; i += 7) begin
         w = IW'($urandom);
         w[IW-1 -: OPC_W] = OPC_JMPR;
         rom[i] = w;
      end
      for (int i = 0; i < 4; i++) rom[i] = '0;
      rom[4]  = ADD_W;
      rom[40] = {OPC_JMPR, 6'b000000, 6'b101100};

      test_reset();
      test_stall();
      test_redirect(1'b0, 10'd19);
      test_redirect(1'b1, 10'd105);
      test_jmpr();
      test_random();
      test_wrap();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
